// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word request at a time to instruction memory,
// buffers responses in a small FIFO for decode, and flushes on a branch redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  output logic        Misaligned
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              stale_q, stale_d;
  logic              misaligned_q, misaligned_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       inst_mem_q [DEPTH];
  logic [31:0]       inst_mem_d [DEPTH];
  logic [31:0]       pc_mem_q [DEPTH];
  logic [31:0]       pc_mem_d [DEPTH];
  logic              push, pop;

  assign InstValid   = (count_q != '0);
  assign ImemReqAddr = fetch_pc_q;
  assign Misaligned  = misaligned_q;
  // Head is gated so an empty buffer always presents zeros.
  assign Inst        = InstValid ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign InstPC      = InstValid ? pc_mem_q[rd_ptr_q] : 32'h0;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    stale_d      = stale_q;
    misaligned_d = misaligned_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    inst_mem_d   = inst_mem_q;
    pc_mem_d     = pc_mem_q;
    push         = 1'b0;
    pop          = 1'b0;
    ImemReqValid = Reset && (state_q == StIssue) && !BranchTaken && !misaligned_q &&
                   (count_q < CntW'(DEPTH));

    if (BranchTaken) begin
      fetch_pc_d = BranchTarget;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if (BranchTarget[1:0] != 2'b00) misaligned_d = 1'b1;
      if (state_q == StWait) begin
        if (ImemRespValid) begin
          stale_d = 1'b0;
          state_d = StIssue;
        end else begin
          stale_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StIssue: begin
          if (ImemReqValid && ImemReqReady) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (ImemRespValid) begin
            push    = !stale_q;
            stale_d = 1'b0;
            state_d = StIssue;
          end
        end
        default: state_d = StIssue;
      endcase

      pop = InstValid && InstReady;
      if (push) begin
        inst_mem_d[wr_ptr_q] = ImemRespData;
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d             = PtrW'(wr_ptr_q + 1'b1);
      end
      if (pop) rd_ptr_d = PtrW'(rd_ptr_q + 1'b1);
      if (push && !pop) count_d = CntW'(count_q + 1'b1);
      else if (pop && !push) count_d = CntW'(count_q - 1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q      <= StIssue;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      stale_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      stale_q      <= stale_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: a latency-randomized memory model and an expected-instruction queue model.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic        clock = 1'b0;
  logic        Reset;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemReqAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] Inst;
  logic [31:0] InstPC;
  logic        Misaligned;

  instr_fetch_unit #(
    .RESET_PC (ResetPc),
    .DEPTH    (Depth)
  ) dut (
    .clock         (clock),
    .Reset         (Reset),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .ImemReqValid  (ImemReqValid),
    .ImemReqReady  (ImemReqReady),
    .ImemReqAddr   (ImemReqAddr),
    .ImemRespValid (ImemRespValid),
    .ImemRespData  (ImemRespData),
    .InstValid     (InstValid),
    .InstReady     (InstReady),
    .Inst          (Inst),
    .InstPC        (InstPC),
    .Misaligned    (Misaligned)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: what decode should see, in order, as {inst, pc} pairs.
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;
  logic        outstanding, drop_resp, mis;
  logic [31:0] out_addr;
  logic        after_reset;

  // Memory model: one outstanding request, response 1..3 cycles after acceptance.
  logic        mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;

  initial begin
    int p_branch, p_rdy, p_inst, seg_len, rst_len;
    logic exp_req, fire;
    Reset = 1'b0; BranchTaken = 1'b0; BranchTarget = '0; ImemReqReady = 1'b0;
    ImemRespValid = 1'b0; ImemRespData = '0; InstReady = 1'b0;
    mem_busy = 1'b0; mem_delay = 0; mem_addr = '0;
    exp_q.delete(); next_pc = ResetPc; outstanding = 0; drop_resp = 0; mis = 0;
    out_addr = '0; after_reset = 0;

    for (int seg = 0; seg < 14; seg++) begin
      p_branch = (seg < 3) ? 0 : ((seg % 2) ? 4 : 10);
      p_rdy    = (seg == 0) ? 100 : ((seg == 2) ? 30 : 75);
      p_inst   = (seg == 0) ? 100 : ((seg == 1) ? 10 : 60);
      seg_len  = 150;
      rst_len  = $urandom_range(1, 2);
      for (int cyc = 0; cyc < seg_len + rst_len; cyc++) begin
        @(negedge clock);
        Reset        = (cyc >= rst_len);
        ImemReqReady = ($urandom_range(0, 99) < p_rdy);
        InstReady    = ($urandom_range(0, 99) < p_inst);
        BranchTaken  = ($urandom_range(0, 99) < p_branch);
        if ($urandom_range(0, 3) == 0) BranchTarget = 32'hFFFF_FFF0;
        else BranchTarget = $urandom() & 32'h0000_0FFC;
        if ($urandom_range(0, 9) == 0) BranchTarget = BranchTarget | 32'($urandom_range(1, 3));
        ImemRespValid = 1'b0;
        if (mem_busy) begin
          mem_delay--;
          if (mem_delay == 0) begin
            ImemRespValid = 1'b1;
            ImemRespData  = 32'h0000_0013 + mem_addr;
          end
        end
        if (!Reset) begin
          // Pre-reset requests never get a response.
          ImemRespValid = 1'b0;
          mem_busy      = 1'b0;
        end
        #1;
        if (!Reset) begin
          check("req_valid_in_reset", {31'b0, ImemReqValid}, 32'd0);
          exp_q.delete(); next_pc = ResetPc; outstanding = 0; drop_resp = 0; mis = 0;
          after_reset = 1;
          continue;
        end

        exp_req = !outstanding && !BranchTaken && !mis && (exp_q.size() < Depth);
        check("req_valid", {31'b0, ImemReqValid}, {31'b0, exp_req});
        if (exp_req) check("req_addr", ImemReqAddr, next_pc);
        check("inst_valid", {31'b0, InstValid}, {31'b0, (exp_q.size() != 0)});
        check("misaligned", {31'b0, Misaligned}, {31'b0, mis});
        if (exp_q.size() != 0) begin
          check("inst", Inst, exp_q[0][63:32]);
          check("inst_pc", InstPC, exp_q[0][31:0]);
        end
        if (after_reset) begin
          check("inst_after_reset", Inst, 32'h0);
          check("inst_pc_after_reset", InstPC, 32'h0);
          after_reset = 0;
        end

        fire = exp_req && ImemReqReady;
        if (ImemRespValid) mem_busy = 1'b0;
        if (BranchTaken) begin
          exp_q.delete();
          next_pc = BranchTarget;
          if (BranchTarget[1:0] != 2'b00) mis = 1;
          if (outstanding && ImemRespValid) begin
            outstanding = 0; drop_resp = 0;
          end else if (outstanding) begin
            drop_resp = 1;
          end
        end else begin
          if (InstReady && exp_q.size() != 0) void'(exp_q.pop_front());
          if (outstanding && ImemRespValid) begin
            if (!drop_resp) exp_q.push_back({32'h0000_0013 + out_addr, out_addr});
            outstanding = 0; drop_resp = 0;
          end
          if (fire) begin
            outstanding = 1;
            out_addr    = next_pc;
            next_pc     = next_pc + 32'd4;
            mem_busy    = 1'b1;
            mem_addr    = out_addr;
            mem_delay   = $urandom_range(1, 3);
          end
        end
      end
    end

    // Closing directed redirect to a misaligned target.
    @(negedge clock);
    Reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0102; ImemRespValid = 1'b0;
    @(negedge clock);
    BranchTaken = 1'b0; ImemReqReady = 1'b1;
    if (mem_busy) begin
      ImemRespValid = 1'b1;
      mem_busy      = 1'b0;
    end
    #1;
    check("mis_set", {31'b0, Misaligned}, 32'd1);
    check("mis_no_req", {31'b0, ImemReqValid}, 32'd0);
    @(negedge clock);
    ImemRespValid = 1'b0;
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    #1;
    check("mis_cleared", {31'b0, Misaligned}, 32'd0);
    check("restart_valid", {31'b0, ImemReqValid}, 32'd1);
    check("restart_addr", ImemReqAddr, ResetPc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the PC / PC+4 / branch-target logic. It owns the fetch PC register, issues word requests to instruction memory over a valid/ready handshake, buffers returned instructions in a small FIFO, and presents them with their PC to decode. It accepts a branch redirect (taken flag plus target), flushes in-flight and buffered instructions, and resumes fetching at the target.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
BranchTaken  input  1  redirect request (ANDBranch of the execute stage)
BranchTarget  input  32  redirect target PC
ImemReqValid  output  1  instruction-memory request valid
ImemReqReady  input  1  memory accepts request
ImemReqAddr  output  32  request byte address (word aligned)
ImemRespValid  input  1  response data valid (in order, one per accepted request)
ImemRespData  input  32  instruction word
InstValid  output  1  buffered instruction available to decode
InstReady  input  1  decode consumes instruction
Inst  output  32  instruction at buffer head
InstPC  output  32  PC of instruction at buffer head
Misaligned  output  1  sticky: redirect target not word aligned

Behaviour:
- One clock, synchronous active-low Reset. While Reset=0 at a clock edge: FetchPC<=RESET_PC, state<=ISSUE, count<=0, Stale<=0, Misaligned<=0. ImemReqValid forced 0 while Reset=0. After reset, InstValid=0, Inst/InstPC=0.
- Memory is reset together with this block. Responses to pre-reset requests never arrive.
- FSM:
  - ISSUE: ImemReqValid = Reset & ~BranchTaken & ~Misaligned & (count < DEPTH). ImemReqAddr=FetchPC. On ReqValid&ReqReady: ReqPC<=FetchPC, FetchPC<=FetchPC+4 (mod 2^32), go WAIT. ImemRespValid ignored in ISSUE.
  - WAIT: ImemReqValid=0, so at most one request is outstanding. On ImemRespValid: if Stale=0 and no redirect this cycle, push {ImemRespData, ReqPC}. Stale<=0, go ISSUE.
- Space check: ISSUE only proceeds when count<DEPTH, so a push never finds the FIFO full. A pop in the same cycle as a push leaves count unchanged.
- Latency: first ImemReqValid in the first cycle with Reset=1. Response at edge N gives InstValid=1 after edge N. With a zero-wait memory, sustained throughput is one instruction per 2 cycles.
- Output: InstValid = (count!=0). Inst/InstPC come from the head entry and hold stable while InstValid & ~InstReady. Pop occurs on InstValid & InstReady.
- Redirect (BranchTaken=1 at an edge) has the highest priority after reset:
  - FetchPC<=BranchTarget, count<=0, and any pop or push that cycle is discarded.
  - In WAIT with no ImemRespValid that cycle: Stale<=1, stay in WAIT, so the next response is dropped.
  - In WAIT with ImemRespValid that cycle: the response is dropped and the FSM goes to ISSUE.
  - Back-to-back redirects: the last target wins and Stale stays 1 until a response arrives.
- Misaligned: a redirect with BranchTarget[1:0]!=0 sets Misaligned (sticky until reset). FetchPC still loads the target, no further requests are issued, and an outstanding response is still drained per the Stale rules.
- Reset mid-operation: Reset overrides redirect, handshake and pop in the same cycle.

Test Plan:
- Reset release, zero-wait memory returning word = 32'h0000_0013 + addr -> requests at 0x0,0x4,0x8; InstPC sequence 0x0,0x4,0x8; Inst = 0x13,0x17,0x1B; ImemReqValid high every other cycle.
- InstReady=0 for 10 cycles -> exactly DEPTH=2 requests accepted, then ImemReqValid=0. Release -> order 0x0,0x4 preserved, fetching resumes at 0x8.
- ImemReqReady held 0 for 3 cycles -> ImemReqAddr stays 0x0, ImemReqValid stays 1, FetchPC does not advance.
- Redirect to 0x100 while in WAIT with response 3 cycles late -> late response dropped, buffer empty, next request address 0x100, first InstPC 0x100.
- Redirect to 0x40 in the same cycle as ImemRespValid and InstReady=1 -> no push, no pop, count=0, next request 0x40.
- Redirect to 0x102 -> Misaligned=1, no further ImemReqValid. Reset low for one cycle -> Misaligned=0 and fetch restarts at RESET_PC.
